// File: rtl/regfile_pkg.sv
// Shared definitions for the ID-stage register file: default sizes,
// FSM state encoding and the hardwired-zero register address.
// Optional feature macro used by the file set: REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int RF_XLEN_DEF  = 32;
  localparam int RF_NREGS_DEF = 32;

  // Register 0 always reads zero and never holds a pending write.
  localparam int unsigned RF_ADDR_ZERO = 0;

  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at
// writeback, wiped on flush; provides one busy lookup per read port.
// REGFILE_BYPASS_EN: a writeback to the register being looked up hides its
// pending bit in the same cycle unless that register is re-issued too.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = RF_NREGS_DEF,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [AW-1:0]     i_wa,
  input  logic              i_set,
  input  logic [AW-1:0]     i_set_addr,
  input  logic              i_flush,
  input  logic [NRD*AW-1:0] i_ra,
  output logic [NRD-1:0]    o_busy
);

  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_pending_nxt;

  // Next pending vector: flush first, then writeback clear, then issue set
  // (the newest producer supersedes the completing one).
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_flush) w_pending_nxt = '0;
    if (i_we) w_pending_nxt[i_wa] = 1'b0;
    if (i_set && (i_set_addr != AW'(RF_ADDR_ZERO))) w_pending_nxt[i_set_addr] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  // Pending bits update only once the file is running; reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else if (i_en) r_pending <= w_pending_nxt;
  end

  // Per-port busy lookup from the registered bits, forced low during init.
  always_comb begin
    logic [AW-1:0] w_addr;
    logic          w_b;
    o_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      w_addr = i_ra[i*AW +: AW];
      w_b    = r_pending[w_addr];
`ifdef REGFILE_BYPASS_EN
      if (i_we && (i_wa != AW'(RF_ADDR_ZERO)) && (w_addr == i_wa))
        w_b = i_set && (i_set_addr == i_wa);
`endif
      o_busy[i] = i_en & w_b;
    end
  end

endmodule

// File: rtl/id_regfile_mp.sv
// Multi-read-port integer register file for the ID stage with a post-reset
// zeroing sweep, pending-write scoreboard and hardwired-zero register 0.
// REGFILE_BYPASS_EN: same-cycle write-through from the write port to any
// read port addressing the register being written.
module id_regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = RF_XLEN_DEF,
  parameter int NREGS = RF_NREGS_DEF,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      busy,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  input  logic                sb_flush,
  output logic                ready
);

  rf_state_e       r_state;
  logic [AW-1:0]   r_cnt;
  logic [XLEN-1:0] r_mem [NREGS];
  logic            w_run;
  logic            w_wr;

  assign w_run = (r_state == RF_RUN);
  assign w_wr  = w_run && we && (wa != AW'(RF_ADDR_ZERO));
  assign ready = w_run;

  // Init sweep: walk every address once after reset, then run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RF_INIT;
      r_cnt   <= '0;
    end else if (r_state == RF_INIT) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == AW'(NREGS - 1)) r_state <= RF_RUN;
    end
  end

  // Storage: zeroed by the sweep, so it carries no reset of its own.
  always_ff @(posedge clk) begin
    if (!w_run) r_mem[r_cnt] <= '0;
    else if (w_wr) r_mem[wa] <= wd;
  end

  // Combinational read ports; zero during init and for register 0.
  always_comb begin
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    rd = '0;
    for (int i = 0; i < NRD; i++) begin
      w_addr = ra[i*AW +: AW];
      w_data = r_mem[w_addr];
`ifdef REGFILE_BYPASS_EN
      if (w_wr && (w_addr == wa)) w_data = wd;
`endif
      if (!w_run || (w_addr == AW'(RF_ADDR_ZERO))) w_data = '0;
      rd[i*XLEN +: XLEN] = w_data;
    end
  end

  regfile_scoreboard #(
    .NREGS(NREGS),
    .NRD  (NRD),
    .AW   (AW)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_run),
    .i_we      (we),
    .i_wa      (wa),
    .i_set     (sb_set),
    .i_set_addr(sb_addr),
    .i_flush   (sb_flush),
    .i_ra      (ra),
    .o_busy    (busy)
  );

endmodule

// File: doc/id_regfile_mp.md
# id_regfile_mp

Parametrised multi-read-port integer register file for the ID stage, successor to the fixed 32×32 two-read-port file. It adds four things the old block lacked:
- a configurable read-port count and configurable data/register widths;
- a post-reset zeroing sweep, so the array itself needs no reset;
- a per-register pending-write scoreboard for hazard detection;
- optional same-cycle write-to-read bypass.

It sits between the decoder (read addresses, destination issue) and the writeback stage (write port).

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of registers; power of two, ≥ 2; register 0 is hardwired zero
- NRD, 2, number of read ports, 1..4
- AW, $clog2(NREGS), address width (derived; not overridden)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ra  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- rd  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
- busy  out  NRD  port i's register has a pending (issued, not written back) write
- we  in  1  write enable (writeback)
- wa  in  AW  write address
- wd  in  XLEN  write data
- sb_set  in  1  mark destination sb_addr pending (instruction issue)
- sb_addr  in  AW  destination register being issued
- sb_flush  in  1  clear all pending bits (pipeline flush)
- ready  out  1  init sweep complete; file usable

## Operation
- **FSM states:** INIT, RUN.
  - rst_n low forces INIT, sweep counter = 0, all pending bits = 0, ready = 0.
- **INIT:**
  - Each cycle writes 0 to register[counter], then increments the counter.
  - When counter = NREGS-1 is written, the next state is RUN.
  - Input effects during INIT:
    - we, sb_set and sb_flush are ignored.
    - rd reads as 0 on every port.
    - busy is 0 on every port.
- **RUN:**
  - Reads are combinational: rd[i] = reg[ra[i]]; address 0 always reads 0.
  - Writes: when we=1 and wa≠0, reg[wa] ← wd on the rising edge. Writes to address 0 are dropped.
- **Scoreboard, one bit per register; bit 0 is constant 0:**
  - Clear: we=1 clears pending[wa].
  - Set: sb_set=1 with sb_addr≠0 sets pending[sb_addr].
  - Set vs clear, same address, same cycle: the set wins, because the new producer supersedes the completing one.
  - Flush: sb_flush=1 clears all bits. A simultaneous sb_set is applied after the flush, so its bit ends up set.
  - Output: busy[i] = pending[ra[i]], taken from the registered bits.
- **Reset mid-operation:** asserting rst_n restarts INIT from counter 0. Array contents are undefined until the sweep rewrites them.

## Timing
- Reset values: ready=0, busy=0, rd=0 (forced while in INIT), state=INIT, counter=0.
- ready rises on the NREGS-th rising edge after rst_n deasserts and stays high until the next reset.
- Read latency is 0 cycles (combinational from ra).
- A write at edge N is visible on rd from edge N onward.
- sb_set at edge N: busy is visible for reads during cycle N+1.
- we clear at edge N: busy drops during cycle N+1. Same-cycle behaviour depends on the macro below.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If we=1, wa≠0 and ra[i]=wa in the same cycle, then rd[i]=wd (write-through).
  - In that same case busy[i]=0, unless sb_set targets the same address in that cycle.
- Undefined: rd[i] returns the old register value and busy[i] reflects the registered pending bit. The decoder must stall one cycle.

## Structure
- Shared package regfile_pkg holds:
  - default XLEN/NREGS;
  - the FSM state enum (RF_INIT, RF_RUN);
  - the address-0 constant.
- One sub-module, regfile_scoreboard: the pending-bit vector with set/clear/flush priority and NRD busy lookups.
- The storage array and the INIT sweep stay in the top level.

## Test plan
- **Reset and sweep:** rst_n low 3 cycles, then high with NREGS=32 → ready=0 for 32 edges, 1 after. Reads of every address return 0 after ready.
- **Write/read and x0:** we=1, wa=5, wd=0xDEADBEEF → rd on ra=5 is 0xDEADBEEF next cycle. we=1, wa=0, wd=0x1 → ra=0 still reads 0.
- **Scoreboard:**
  - sb_set for addr 7 → busy=1 on ra=7 next cycle.
  - Later we to wa=7 → busy=0 the following cycle.
  - sb_set for 7 and we to 7 in the same cycle → busy stays 1.
- **Flush:** pending bits 3, 9, 12 set; sb_flush together with sb_set for 4 → only bit 4 remains set.
- **Bypass (REGFILE_BYPASS_EN):** we=1, wa=10, wd=0x55, with ra[1]=10 in the same cycle → rd[1]=0x55, busy[1]=0. Without the macro → the old value and busy[1]=1.
- **Mid-op reset:** pulse rst_n low in RUN with pending bits set → ready=0 and busy=0 immediately, and the sweep repeats all 32 cycles.
